// File: rtl/adpcm_pkg.sv
// Shared helpers for the ADPCM delta encoder: code range, saturation, pixel clamp, lane slicing.
// ADPCM_LANE(c, w) expands to the part-select of lane c in a word of w-bit lanes.
`ifndef ADPCM_LANE
`define ADPCM_LANE(c, w) ((c)*(w)) +: (w)
`endif

package adpcm_pkg;

  function automatic int code_max(input int qw);
    return (1 << (qw - 1)) - 1;
  endfunction

  function automatic int code_min(input int qw);
    return -(1 << (qw - 1));
  endfunction

  function automatic int sat_code(input int q, input int qw);
    if (q > code_max(qw)) return code_max(qw);
    if (q < code_min(qw)) return code_min(qw);
    return q;
  endfunction

  function automatic int clamp_pix(input int r, input int dw);
    if (r < 0) return 0;
    if (r > (1 << dw) - 1) return (1 << dw) - 1;
    return r;
  endfunction

  // A counter modulo 1 still needs one bit to exist.
  function automatic int key_width(input int key_int);
    return (key_int > 1) ? $clog2(key_int) : 1;
  endfunction

endpackage

// File: rtl/adpcm_delta_enc_quant_lane.sv
// One channel of the delta encoder: difference, floor quantise with saturation, and the
// decoder-matching reconstruction that becomes the next predictor.
module adpcm_quant_lane
  import adpcm_pkg::*;
#(
  parameter int DW    = 8,
  parameter int QW    = 4,
  parameter int SHIFT = 3
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] pred,
  output logic [QW-1:0] q,
  output logic [DW-1:0] r,
  output logic          sat
);

  logic signed [DW:0] diff;
  logic signed [DW:0] diff_sh;

  assign diff    = $signed({1'b0, x}) - $signed({1'b0, pred});
  // Arithmetic shift rounds toward minus infinity, matching the decoder.
  assign diff_sh = diff >>> SHIFT;

  assign q   = QW'(sat_code(int'(diff_sh), QW));
  assign sat = (sat_code(int'(diff_sh), QW) != int'(diff_sh));
  assign r   = DW'(clamp_pix(int'({1'b0, pred}) + (int'($signed(q)) <<< SHIFT), DW));

endmodule

// File: rtl/adpcm_delta_enc.sv
// Delta (ADPCM-style) encoder for packed YCbCr words: periodic raw key samples, quantised deltas otherwise.
// Optional saturation statistics counter on sat_cnt when ADPCM_STATS_EN is defined.
module adpcm_delta_enc
  import adpcm_pkg::*;
#(
  parameter int CH      = 2,
  parameter int DW      = 8,
  parameter int QW      = 4,
  parameter int SHIFT   = 3,
  parameter int KEY_INT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sol,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_key,
  output logic [CH*DW-1:0]   dout
`ifdef ADPCM_STATS_EN
  ,
  output logic [15:0]        sat_cnt
`endif
);

  localparam int            KW        = key_width(KEY_INT);
  localparam logic [KW-1:0] KCNT_LAST = KW'(KEY_INT - 1);
  localparam logic [KW-1:0] KCNT_SOL  = KW'(1 % KEY_INT);

  // Handshake: a word moves on a clock edge where valid & ready are both high; the source holds
  // valid and data until then. Both stages advance together on en, so in_ready is en itself.
  logic            en;
  logic            accept;
  logic            key;
  logic [KW-1:0]   kcnt;

  logic [DW-1:0]   pred    [CH];
  logic [QW-1:0]   lane_q  [CH];
  logic [DW-1:0]   lane_r  [CH];
  logic [CH-1:0]   lane_sat;

  logic [CH*DW-1:0] code_word;
  logic [CH*DW-1:0] s1_word_d;
  logic [CH*DW-1:0] s1_word;
  logic             s1_valid;
  logic             s1_key;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign key      = sol || (kcnt == '0);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    adpcm_quant_lane #(
      .DW    (DW),
      .QW    (QW),
      .SHIFT (SHIFT)
    ) u_lane (
      .x    (din[`ADPCM_LANE(c, DW)]),
      .pred (pred[c]),
      .q    (lane_q[c]),
      .r    (lane_r[c]),
      .sat  (lane_sat[c])
    );
  end

  always_comb begin
    code_word = '0;
    for (int c = 0; c < CH; c++) begin
      code_word[`ADPCM_LANE(c, QW)] = lane_q[c];
    end
    s1_word_d = key ? din : code_word;
  end

  // Stage 1: key decision, code packing and predictor update all happen on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_key   <= 1'b0;
      s1_word  <= '0;
      kcnt     <= '0;
      for (int c = 0; c < CH; c++) begin
        pred[c] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      s1_key   <= in_valid && key;
      s1_word  <= in_valid ? s1_word_d : '0;
      if (in_valid) begin
        if (sol) begin
          kcnt <= KCNT_SOL;
        end else if (kcnt == KCNT_LAST) begin
          kcnt <= '0;
        end else begin
          kcnt <= kcnt + 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
          pred[c] <= key ? din[`ADPCM_LANE(c, DW)] : lane_r[c];
        end
      end
    end
  end

  // Stage 2: output register; an empty slot carries an all-zero word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_key   <= 1'b0;
      dout      <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_key   <= s1_key;
      dout      <= s1_word;
    end
  end

`ifdef ADPCM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (accept && !key && (|lane_sat) && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  // Saturation flags only feed the statistics counter.
  logic unused_sat;
  assign unused_sat = |lane_sat;
`endif

endmodule
